tx_fifo: RTL and testbench



---
 rtl/tx_fifo_pkg.sv | 14 +
 rtl/tx_fifo_mem.sv | 25 ++
 rtl/tx_fifo.sv | 94 +++++++++
 tb/tb_tx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_pkg.sv
// Shared types and default sizing for the controller-to-UART byte FIFO.
package tx_fifo_pkg;

  localparam int TXF_DATA_WIDTH = 8;
  localparam int TXF_DEPTH      = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_fifo_state_e;

endpackage

// File: rtl/tx_fifo_mem.sv
// Byte storage for tx_fifo: registered write port, combinational read port.
module tx_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_fifo.sv
// Byte FIFO between the system controller and the UART transmitter; the read
// side presents one byte, pulses TX_D_VLD, and pops once TX_BUSY acknowledges.
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = TXF_DATA_WIDTH,
  parameter  int DEPTH      = TXF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_INC,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en, pop, load;
  tx_fifo_state_e        state_q, state_d;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign EMPTY = (wptr == rptr);
  assign FULL  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign COUNT = wptr - rptr;
  assign wr_en = WR_INC && !FULL;

  tx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .CLK   (CLK),
    .RST   (RST),
    .we    (wr_en),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (WR_DATA),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    pop      = 1'b0;
    TX_D_VLD = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!EMPTY) begin
          load    = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        TX_D_VLD = 1'b1;
        state_d  = ST_WAIT_BUSY;
      end
      // The entry stays occupied until the transmitter has taken it.
      ST_WAIT_BUSY: begin
        if (TX_BUSY) begin
          pop     = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      TX_P_DATA <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) wptr      <= wptr + PTR_ONE;
      if (pop)   rptr      <= rptr + PTR_ONE;
      if (load)  TX_P_DATA <= rd_data;
    end
  end

endmodule

// File: tb/tb_tx_fifo.sv
// Randomized and directed checks of tx_fifo against a queue model with a
// bench-side UART responder driving TX_BUSY.
module tb_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0, RST = 1'b0, WR_INC = 1'b0, TX_BUSY = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          FULL, EMPTY, TX_D_VLD;
  logic [AW:0]   COUNT;
  logic [DW-1:0] TX_P_DATA;

  tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_DATA   (WR_DATA),
    .WR_INC    (WR_INC),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_BUSY   (TX_BUSY)
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0, n_err = 0;
  logic [7:0] q[$];
  logic [7:0] tx_log[$];
  bit         wait_pop = 0, skip = 0, uart_en = 0, uart_rand = 0;
  int         ph = 0, dly = 0, bcnt = 0, busy_len = 2, stall = 0;
  logic       prev_vld = 1'b0;
  logic [7:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: update the model at the edge, check at edge+1, then drive TX_BUSY.
  task automatic step();
    bit do_pop;
    int sz;
    @(posedge CLK);
    do_pop = 0;
    sz     = q.size();
    if (!RST) begin
      if (wait_pop) begin
        if (skip) skip = 0;
        else if (TX_BUSY) do_pop = 1;
      end
      if (WR_INC && sz < DEPTH) q.push_back(WR_DATA);
      if (do_pop) begin
        void'(q.pop_front());
        wait_pop = 0;
      end
    end
    #1;
    chk("count", COUNT, q.size());
    chk("empty", EMPTY, q.size() == 0);
    chk("full",  FULL,  q.size() == DEPTH);
    if (TX_D_VLD) begin
      chk("vld_phase", ph, 0);
      chk("vld_width", prev_vld, 0);
      chk("vld_nonempty", q.size() != 0, 1);
      if (q.size() != 0) chk("tx_data", TX_P_DATA, q[0]);
      tx_log.push_back(TX_P_DATA);
      held     = TX_P_DATA;
      wait_pop = 1;
      skip     = 1;
      ph       = 1;
      dly      = uart_rand ? $urandom_range(0, 3) : 0;
      stall    = 0;
    end else if (ph != 0) begin
      chk("tx_hold", TX_P_DATA, held);
    end else if (q.size() != 0) begin
      stall++;
      if (stall > 4) begin
        chk("vld_timeout", stall, 0);
        stall = 0;
      end
    end
    prev_vld = TX_D_VLD;
    if (ph == 1 && uart_en) begin
      if (dly > 0) dly--;
      else begin
        TX_BUSY = 1'b1;
        ph      = 2;
        bcnt    = uart_rand ? $urandom_range(1, 6) : busy_len;
      end
    end else if (ph == 2) begin
      if (bcnt > 0) bcnt--;
      else if (!wait_pop) begin
        TX_BUSY = 1'b0;
        ph      = 0;
      end
    end
  endtask

  task automatic mid_reset();
    #3;
    RST = 1'b1;
    #1;
    q.delete();
    wait_pop = 0; skip = 0; ph = 0; stall = 0; prev_vld = 1'b0;
    TX_BUSY  = 1'b0; WR_INC = 1'b0;
    chk("rst_empty", EMPTY, 1);
    chk("rst_count", COUNT, 0);
    chk("rst_full",  FULL, 0);
    chk("rst_vld",   TX_D_VLD, 0);
    chk("rst_data",  TX_P_DATA, 0);
    step();
    RST = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || ph != 0) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) chk("drain_timeout", n, 0);
    repeat (3) step();
  endtask

  task automatic push(input logic [7:0] d);
    WR_DATA = d;
    WR_INC  = 1'b1;
    step();
    WR_INC  = 1'b0;
  endtask

  initial begin
    #1 RST = 1'b1;
    #1;
    chk("init_empty", EMPTY, 1);
    chk("init_count", COUNT, 0);
    chk("init_full",  FULL, 0);
    chk("init_vld",   TX_D_VLD, 0);
    chk("init_data",  TX_P_DATA, 0);
    step();
    RST = 1'b0;

    // Single byte: pulse in the cycle after the write edge.
    tx_log.delete();
    push(8'hA5);
    step();
    chk("single_vld",  TX_D_VLD, 1);
    chk("single_data", TX_P_DATA, 8'hA5);
    busy_len = 10;
    uart_en  = 1;
    drain();
    chk("single_n", tx_log.size(), 1);
    chk("single_b", tx_log[0], 8'hA5);
    chk("single_empty", EMPTY, 1);

    // Fill with the transmitter stalled; the ninth byte is dropped.
    busy_len = 2;
    uart_en  = 0;
    tx_log.delete();
    for (int i = 1; i <= 9; i++) begin
      push(8'(i));
      if (i == 8) begin
        chk("fill_full8",  FULL, 1);
        chk("fill_count8", COUNT, 8);
      end
    end
    chk("fill_count9", COUNT, 8);
    uart_en = 1;
    drain();
    chk("fill_n", tx_log.size(), 8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++) chk("fill_order", tx_log[i], i + 1);

    // Wrap across the last index.
    uart_en = 0;
    tx_log.delete();
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    uart_en = 1;
    drain();
    uart_en = 0;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    uart_en = 1;
    drain();
    chk("wrap_n", tx_log.size(), 11);
    for (int i = 0; i < 11 && i < tx_log.size(); i++)
      chk("wrap_order", tx_log[i], (i < 6) ? 8'h20 + i : 8'h30 + i - 6);

    // Write coinciding with the pop edge, three entries held.
    uart_en = 0;
    tx_log.delete();
    push(8'h11); push(8'h22); push(8'h33);
    step(); step();
    uart_en = 1;
    step();
    push(8'h44);
    chk("simul_count", COUNT, 3);
    drain();
    chk("simul_n", tx_log.size(), 4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++) chk("simul_order", tx_log[i], 8'h11 * (i + 1));

    // Same while FULL: the write is dropped despite the pop.
    uart_en = 0;
    tx_log.delete();
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    step();
    uart_en = 1;
    step();
    push(8'hEE);
    chk("fullpop_count", COUNT, 7);
    drain();
    chk("fullpop_n", tx_log.size(), 8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++) chk("fullpop_order", tx_log[i], 8'h50 + i);

    // Reset while the transmitter is busy with a popped byte.
    busy_len = 10;
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    begin
      int n = 0;
      while (!(ph == 2 && !wait_pop) && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) chk("rstxfer_reach", n, 0);
    end
    mid_reset();
    tx_log.delete();
    push(8'h3C);
    drain();
    chk("rstxfer_n", tx_log.size(), 1);
    if (tx_log.size() != 0) chk("rstxfer_b", tx_log[0], 8'h3C);

    // Random traffic with random transmitter timing and rare resets.
    uart_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      WR_INC  = ($urandom_range(0, 99) < ((c < 1500) ? 40 : 15));
      WR_DATA = 8'($urandom);
      step();
      if ($urandom_range(0, 999) == 0) mid_reset();
    end
    WR_INC = 1'b0;
    drain();
    chk("final_empty", EMPTY, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
